// File: rtl/pc_ctrl.sv
// Program-counter controller: owns PC/EPC, sequences exception entry and RFE.
// Optional target alignment check is enabled with `define PC_CTRL_ALIGN_CHECK_EN.
module pc_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic        req_taken,
   output logic        req_ready,
   output logic        done,
   output logic [1:0]  pcsrc_selector,
   input  logic [31:0] pcsrc_in,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EXEC     = 2'd1,
      S_EXC_SAVE = 2'd2,
      S_EXC_VEC  = 2'd3
   } state_t;

   localparam logic [2:0] OP_NEXT   = 3'b000;
   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_JR     = 3'b011;
   localparam logic [2:0] OP_EXC    = 3'b100;
   localparam logic [2:0] OP_RFE    = 3'b101;

   localparam logic [1:0] SEL_ULA    = 2'b00;
   localparam logic [1:0] SEL_JUMP   = 2'b01;
   localparam logic [1:0] SEL_REGULA = 2'b10;
   localparam logic [1:0] SEL_EPC    = 2'b11;

   state_t      state_q;
   logic [2:0]  op_q;
   logic        taken_q;
   logic [1:0]  pend_cause_q;
   logic [31:0] pc_q;
   logic [31:0] epc_q;
   logic [1:0]  cause_q;
   logic [1:0]  sel_q;
   logic        done_q;
   logic        write_due;
   logic        align_fault;

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only in IDLE and out of reset.
   assign req_ready = reset_n & (state_q == S_IDLE);

   assign write_due = !((op_q == OP_BRANCH) && !taken_q);

`ifdef PC_CTRL_ALIGN_CHECK_EN
   assign align_fault = write_due && (pcsrc_in[1:0] != 2'b00);
`else
   assign align_fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         op_q         <= OP_NEXT;
         taken_q      <= 1'b0;
         pend_cause_q <= 2'd0;
         pc_q         <= RESET_PC;
         epc_q        <= 32'h0000_0000;
         cause_q      <= 2'd0;
         sel_q        <= SEL_ULA;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               sel_q <= SEL_ULA;
               if (req_valid) begin
                  op_q    <= req_op;
                  taken_q <= req_taken;
                  case (req_op)
                     OP_NEXT:   begin sel_q <= SEL_ULA;    state_q <= S_EXEC; end
                     OP_BRANCH: begin sel_q <= SEL_REGULA; state_q <= S_EXEC; end
                     OP_JUMP:   begin sel_q <= SEL_JUMP;   state_q <= S_EXEC; end
                     OP_JR:     begin sel_q <= SEL_ULA;    state_q <= S_EXEC; end
                     OP_RFE:    begin sel_q <= SEL_EPC;    state_q <= S_EXEC; end
                     OP_EXC: begin
                        pend_cause_q <= 2'd1;
                        state_q      <= S_EXC_SAVE;
                     end
                     default: begin
                        pend_cause_q <= 2'd3;
                        state_q      <= S_EXC_SAVE;
                     end
                  endcase
               end
            end
            S_EXEC: begin
               sel_q <= SEL_ULA;
               if (align_fault) begin
                  // Misaligned target: PC stays put so EPC records the faulting instruction.
                  pend_cause_q <= 2'd2;
                  state_q      <= S_EXC_SAVE;
               end else begin
                  if (write_due) pc_q <= pcsrc_in;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            S_EXC_SAVE: begin
               sel_q   <= SEL_ULA;
               epc_q   <= pc_q;
               cause_q <= pend_cause_q;
               state_q <= S_EXC_VEC;
            end
            S_EXC_VEC: begin
               sel_q   <= SEL_ULA;
               pc_q    <= EXC_VECTOR;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               sel_q   <= SEL_ULA;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign done           = done_q;
   assign pcsrc_selector = sel_q;
   assign pc             = pc_q;
   assign epc            = epc_q;
   assign cause          = cause_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl; the PC-source mux is modelled around the DUT.
module tb_pc_ctrl;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic [2:0]  req_op;
   logic        req_taken;
   logic        req_ready;
   logic        done;
   logic [1:0]  pcsrc_selector;
   logic [31:0] pcsrc_in;
   logic [31:0] pc;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic [1:0]  dbg_state;

   logic [31:0] jmp_in;
   logic [31:0] regula_in;
   logic [31:0] epc_in;

   int checks;
   int errors;

   pc_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_op         (req_op),
      .req_taken      (req_taken),
      .req_ready      (req_ready),
      .done           (done),
      .pcsrc_selector (pcsrc_selector),
      .pcsrc_in       (pcsrc_in),
      .pc             (pc),
      .epc            (epc),
      .cause          (cause),
      .dbg_state_o    (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC-source mux: ULA computes PC+4, the others are bench-supplied sources.
   always_comb begin
      pcsrc_in = pc + 32'd4;
      case (pcsrc_selector)
         2'b00: pcsrc_in = pc + 32'd4;
         2'b01: pcsrc_in = jmp_in;
         2'b10: pcsrc_in = regula_in;
         2'b11: pcsrc_in = epc_in;
         default: pcsrc_in = pc + 32'd4;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic taken);
      req_valid = 1'b1;
      req_op    = op;
      req_taken = taken;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", req_ready); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
      checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", epc); end
      checks++; if (cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d exp 0", cause); end
      checks++; if (pcsrc_selector !== 2'b00) begin errors++; $display("FAIL reset_sel got %0d exp 0", pcsrc_selector); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
      reset_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b exp 1", req_ready); end
   endtask

   task automatic test_next();
      issue(3'b000, 1'b0);
      checks++; if (pcsrc_selector !== 2'b00) begin errors++; $display("FAIL next_sel got %0d exp 0", pcsrc_selector); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL next_ready_exec got %0b exp 0", req_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL next_done_early got %0b exp 0", done); end
      checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL next_state got %0d exp 1", dbg_state); end
      tick();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL next_pc got %h exp 4", pc); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL next_done got %0b exp 1", done); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL next_ready_back got %0b exp 1", req_ready); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL next_done_width got %0b exp 0", done); end
   endtask

   task automatic test_branch();
      regula_in = 32'h40;
      issue(3'b001, 1'b1);
      checks++; if (pcsrc_selector !== 2'b10) begin errors++; $display("FAIL br_taken_sel got %0d exp 2", pcsrc_selector); end
      tick();
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_taken_pc got %h exp 40", pc); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL br_taken_done got %0b exp 1", done); end
      tick();
      regula_in = 32'h80;
      issue(3'b001, 1'b0);
      checks++; if (pcsrc_selector !== 2'b10) begin errors++; $display("FAIL br_nt_sel got %0d exp 2", pcsrc_selector); end
      tick();
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_nt_pc got %h exp 40", pc); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL br_nt_done got %0b exp 1", done); end
      tick();
   endtask

   task automatic test_exc_rfe();
      jmp_in = 32'h100;
      issue(3'b010, 1'b0);
      checks++; if (pcsrc_selector !== 2'b01) begin errors++; $display("FAIL jump_sel got %0d exp 1", pcsrc_selector); end
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jump_pc got %h exp 100", pc); end
      tick();
      issue(3'b100, 1'b0);
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL exc_state_save got %0d exp 2", dbg_state); end
      checks++; if (pcsrc_selector !== 2'b00) begin errors++; $display("FAIL exc_sel got %0d exp 0", pcsrc_selector); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL exc_ready got %0b exp 0", req_ready); end
      tick();
      checks++; if (epc !== 32'h100) begin errors++; $display("FAIL exc_epc got %h exp 100", epc); end
      checks++; if (cause !== 2'd1) begin errors++; $display("FAIL exc_cause got %0d exp 1", cause); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL exc_done_early got %0b exp 0", done); end
      tick();
      checks++; if (pc !== 32'hFC) begin errors++; $display("FAIL exc_pc got %h exp fc", pc); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL exc_done got %0b exp 1", done); end
      tick();
      epc_in = 32'h100;
      issue(3'b101, 1'b0);
      checks++; if (pcsrc_selector !== 2'b11) begin errors++; $display("FAIL rfe_sel got %0d exp 3", pcsrc_selector); end
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rfe_pc got %h exp 100", pc); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rfe_done got %0b exp 1", done); end
      checks++; if (cause !== 2'd1) begin errors++; $display("FAIL rfe_cause got %0d exp 1", cause); end
      tick();
   endtask

   task automatic test_illegal();
      jmp_in = 32'h20;
      issue(3'b010, 1'b0);
      tick();
      tick();
      issue(3'b110, 1'b0);
      tick();
      checks++; if (epc !== 32'h20) begin errors++; $display("FAIL ill6_epc got %h exp 20", epc); end
      checks++; if (cause !== 2'd3) begin errors++; $display("FAIL ill6_cause got %0d exp 3", cause); end
      tick();
      checks++; if (pc !== 32'hFC) begin errors++; $display("FAIL ill6_pc got %h exp fc", pc); end
      tick();
      issue(3'b111, 1'b0);
      tick();
      checks++; if (epc !== 32'hFC) begin errors++; $display("FAIL ill7_epc got %h exp fc", epc); end
      checks++; if (cause !== 2'd3) begin errors++; $display("FAIL ill7_cause got %0d exp 3", cause); end
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ill7_done got %0b exp 1", done); end
      tick();
   endtask

   task automatic test_align();
      jmp_in = 32'h8;
      issue(3'b010, 1'b0);
      tick();
      tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL align_setup_pc got %h exp 8", pc); end
      jmp_in = 32'h42;
      issue(3'b010, 1'b0);
      tick();
`ifdef PC_CTRL_ALIGN_CHECK_EN
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL align_done got %0b exp 0", done); end
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL align_pc_held got %h exp 8", pc); end
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL align_state got %0d exp 2", dbg_state); end
      tick();
      checks++; if (epc !== 32'h8) begin errors++; $display("FAIL align_epc got %h exp 8", epc); end
      checks++; if (cause !== 2'd2) begin errors++; $display("FAIL align_cause got %0d exp 2", cause); end
      tick();
      checks++; if (pc !== 32'hFC) begin errors++; $display("FAIL align_pc got %h exp fc", pc); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL align_vec_done got %0b exp 1", done); end
`else
      checks++; if (pc !== 32'h42) begin errors++; $display("FAIL noalign_pc got %h exp 42", pc); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL noalign_done got %0b exp 1", done); end
      checks++; if (cause !== 2'd3) begin errors++; $display("FAIL noalign_cause got %0d exp 3", cause); end
`endif
      tick();
   endtask

   task automatic test_reset_mid();
      int seen_done;
      seen_done = 0;
      issue(3'b100, 1'b0);
      reset_n = 1'b0;
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rmid_pc got %h exp 0", pc); end
      checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rmid_epc got %h exp 0", epc); end
      checks++; if (cause !== 2'd0) begin errors++; $display("FAIL rmid_cause got %0d exp 0", cause); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %0b exp 0", req_ready); end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) seen_done++;
         tick();
      end
      checks++; if (seen_done !== 0) begin errors++; $display("FAIL rmid_done got %0d exp 0", seen_done); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d exp 0", dbg_state); end
   endtask

   task automatic test_back_to_back();
      int accepts;
      int dones;
      accepts = 0;
      dones   = 0;
      req_valid = 1'b1;
      req_op    = 3'b000;
      req_taken = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (req_valid && req_ready) accepts++;
         tick();
         if (done === 1'b1) dones++;
      end
      req_valid = 1'b0;
      checks++; if (accepts !== 5) begin errors++; $display("FAIL b2b_next_accepts got %0d exp 5", accepts); end
      checks++; if (dones !== 5) begin errors++; $display("FAIL b2b_next_dones got %0d exp 5", dones); end
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL b2b_next_pc got %h exp 14", pc); end
      tick();
      accepts = 0;
      dones   = 0;
      req_valid = 1'b1;
      req_op    = 3'b100;
      for (int i = 0; i < 6; i++) begin
         if (req_valid && req_ready) accepts++;
         tick();
         if (done === 1'b1) dones++;
      end
      req_valid = 1'b0;
      checks++; if (accepts !== 2) begin errors++; $display("FAIL b2b_exc_accepts got %0d exp 2", accepts); end
      checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_exc_dones got %0d exp 2", dones); end
      checks++; if (epc !== 32'hFC) begin errors++; $display("FAIL b2b_exc_epc got %h exp fc", epc); end
      checks++; if (cause !== 2'd1) begin errors++; $display("FAIL b2b_exc_cause got %0d exp 1", cause); end
      checks++; if (pc !== 32'hFC) begin errors++; $display("FAIL b2b_exc_pc got %h exp fc", pc); end
      tick();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 3'b000;
      req_taken = 1'b0;
      jmp_in    = 32'h0;
      regula_in = 32'h0;
      epc_in    = 32'h0;
      test_reset();
      test_next();
      test_branch();
      test_exc_rfe();
      test_illegal();
      test_align();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
